// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART transmitter and the
// future receiver.
//   parity_t        - parity mode for a frame (none / even / odd)
//   uart_tx_state_t - transmitter FSM states
//   calc_parity()   - parity bit for a data word, zero-extended to 16 bits
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_t;

  // State literals carry an ST_ prefix so they cannot collide with the
  // PARITY parameter of the transmitter.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  localparam int MAX_DATA_WIDTH = 16;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  // Unused upper bits must be zero.
  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] word,
                                       input parity_t mode);
    return (mode == PARITY_ODD) ? ~(^word) : (^word);
  endfunction

endpackage

// File: rtl/uart_transmit_framed_if.sv
// uart_transmit_framed_if: valid/ready word handshake into the UART
// transmitter.
//   data_in   - word to send (producer -> transmitter)
//   valid_in  - data_in is valid (producer -> transmitter)
//   ready_out - transmitter can accept a word (transmitter -> producer)
// master: the producer side; slave: the transmitter side.
interface uart_transmit_framed_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  ready_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous show-ahead word FIFO.
//   clk_in, rst_in - clock and synchronous active-high reset
//   push, wr_data  - write a word (ignored while full)
//   pop            - drop the head word (ignored while empty)
//   rd_data        - head word, valid whenever empty is low
//   full, empty    - derived from the registered count
//   count          - words currently stored, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_transmit_framed.sv
// uart_transmit_framed: buffered UART transmitter with configurable data
// width, optional parity and one or two stop bits.
//   clk_in         - clock
//   rst_in         - synchronous active-high reset (aborts any frame)
//   tx_if          - valid/ready word input (slave side)
//   busy_out       - FSM active or words still queued
//   fifo_count_out - words waiting in the FIFO
//   tx_wire_out    - registered serial line, idle high
// Frames go out back to back with no idle gap while words are queued.
module uart_transmit_framed
  import uart_pkg::*;
#(
  parameter int      INPUT_CLOCK_FREQ = 100_000_000,
  parameter int      BAUD_RATE        = 9600,
  parameter int      DATA_WIDTH       = 8,
  parameter parity_t PARITY           = PARITY_NONE,
  parameter int      STOP_BITS        = 1,
  parameter int      FIFO_DEPTH       = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  uart_transmit_framed_if.slave         tx_if,
  output logic                          busy_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          tx_wire_out
);

  localparam int BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int BAUD_W          = $clog2(BAUD_BIT_PERIOD);
  localparam int BIT_W           = $clog2(DATA_WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_BIT_PERIOD - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);

  uart_tx_state_t        state;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  stop_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  parity_bit;

  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  baud_end;
  logic                  last_stop;
  logic                  shift_en;

  assign tx_if.ready_out = !fifo_full;
  assign push            = tx_if.valid_in && !fifo_full;

  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign last_stop = (state == ST_STOP) && baud_end && (stop_cnt == STOP_LAST);
  // A word leaves the FIFO either from idle or exactly at the end of the
  // last stop bit, which is what keeps consecutive frames gap-free.
  assign pop       = !fifo_empty && ((state == ST_IDLE) || last_stop);
  assign shift_en  = baud_end &&
                     ((state == ST_START) ||
                      ((state == ST_DATA) && (bit_cnt != BIT_LAST)));

  assign busy_out = (state != ST_IDLE) || !fifo_empty;

  uart_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push    (push),
    .pop     (pop),
    .wr_data (tx_if.data_in),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_out)
  );

  // Word capture: the frame in flight is decoupled from the FIFO once popped.
  always_ff @(posedge clk_in) begin
    if (pop) begin
      shift_reg  <= fifo_rd_data;
      parity_bit <= calc_parity(MAX_DATA_WIDTH'(fifo_rd_data), PARITY);
    end else if (shift_en) begin
      shift_reg  <= shift_reg >> 1;
    end
  end

  // Bit sequencing: the line is updated on the same edge the state advances.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= ST_IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      tx_wire_out <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt    <= '0;
          tx_wire_out <= 1'b1;
          if (!fifo_empty) begin
            tx_wire_out <= 1'b0;
            state       <= ST_START;
          end
        end

        ST_START: begin
          if (baud_end) begin
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            tx_wire_out <= shift_reg[0];
            state       <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        ST_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              if (PARITY != PARITY_NONE) begin
                tx_wire_out <= parity_bit;
                state       <= ST_PARITY;
              end else begin
                tx_wire_out <= 1'b1;
                stop_cnt    <= 1'b0;
                state       <= ST_STOP;
              end
            end else begin
              tx_wire_out <= shift_reg[0];
              bit_cnt     <= bit_cnt + BIT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        ST_PARITY: begin
          if (baud_end) begin
            baud_cnt    <= '0;
            tx_wire_out <= 1'b1;
            stop_cnt    <= 1'b0;
            state       <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        ST_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (stop_cnt == STOP_LAST) begin
              if (!fifo_empty) begin
                tx_wire_out <= 1'b0;
                state       <= ST_START;
              end else begin
                tx_wire_out <= 1'b1;
                state       <= ST_IDLE;
              end
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          tx_wire_out <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmit_framed.sv
// tb_uart_transmit_framed: four transmitter configurations driven side by
// side (period 16 cycles). Each accepted word is turned into its expected
// line waveform from the frame rules, placed after the previous frame or one
// cycle after acceptance, and every cycle the line, busy, ready and count are
// compared with that reference.
module tb_uart_transmit_framed;
  import uart_pkg::*;

  localparam int P     = 16;
  localparam int NI    = 4;
  localparam int NCYC  = 16384;
  localparam int DEPTH = 4;
  localparam int DWA  [NI] = '{8, 8, 8, 12};
  localparam int PARA [NI] = '{0, 1, 2, 1};   // 0 none, 1 even, 2 odd
  localparam int STA  [NI] = '{1, 1, 2, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [NI];
  logic        vld  [NI];
  logic [15:0] dat  [NI];
  logic        tx   [NI];
  logic        busy [NI];
  logic        rdy  [NI];
  logic [2:0]  cnt  [NI];

  logic exp_line [NI][NCYC];
  int   pend     [NI][$];
  int   last_end [NI];
  int   cyc;
  int   n_checks = 0;
  int   n_errors = 0;

  uart_transmit_framed_if #(.DATA_WIDTH(8))  if0 ();
  uart_transmit_framed_if #(.DATA_WIDTH(8))  if1 ();
  uart_transmit_framed_if #(.DATA_WIDTH(8))  if2 ();
  uart_transmit_framed_if #(.DATA_WIDTH(12)) if3 ();

  assign if0.valid_in = vld[0];  assign if0.data_in = dat[0][7:0];  assign rdy[0] = if0.ready_out;
  assign if1.valid_in = vld[1];  assign if1.data_in = dat[1][7:0];  assign rdy[1] = if1.ready_out;
  assign if2.valid_in = vld[2];  assign if2.data_in = dat[2][7:0];  assign rdy[2] = if2.ready_out;
  assign if3.valid_in = vld[3];  assign if3.data_in = dat[3][11:0]; assign rdy[3] = if3.ready_out;

  uart_transmit_framed #(.INPUT_CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_WIDTH(8),
    .PARITY(PARITY_NONE), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut0 (
    .clk_in(clk), .rst_in(rst[0]), .tx_if(if0.slave), .busy_out(busy[0]),
    .fifo_count_out(cnt[0]), .tx_wire_out(tx[0]));

  uart_transmit_framed #(.INPUT_CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_WIDTH(8),
    .PARITY(PARITY_EVEN), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .clk_in(clk), .rst_in(rst[1]), .tx_if(if1.slave), .busy_out(busy[1]),
    .fifo_count_out(cnt[1]), .tx_wire_out(tx[1]));

  uart_transmit_framed #(.INPUT_CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_WIDTH(8),
    .PARITY(PARITY_ODD), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_dut2 (
    .clk_in(clk), .rst_in(rst[2]), .tx_if(if2.slave), .busy_out(busy[2]),
    .fifo_count_out(cnt[2]), .tx_wire_out(tx[2]));

  uart_transmit_framed #(.INPUT_CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_WIDTH(12),
    .PARITY(PARITY_EVEN), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_dut3 (
    .clk_in(clk), .rst_in(rst[3]), .tx_if(if3.slave), .busy_out(busy[3]),
    .fifo_count_out(cnt[3]), .tx_wire_out(tx[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Lay down the frame for word d, accepted at edge t, on instance i's line.
  task automatic schedule(input int i, input int t, input logic [15:0] d);
    int   s;
    int   pos;
    logic p;
    logic bits [$];
    s = (t + 1 > last_end[i]) ? t + 1 : last_end[i];
    p = 1'b0;
    bits.push_back(1'b0);
    for (int b = 0; b < DWA[i]; b++) begin
      bits.push_back(d[b]);
      p = p ^ d[b];
    end
    if (PARA[i] != 0) bits.push_back((PARA[i] == 2) ? ~p : p);
    for (int b = 0; b < STA[i]; b++) bits.push_back(1'b1);
    pos = s;
    foreach (bits[k]) begin
      for (int c = 0; c < P; c++) begin
        if (pos < NCYC) exp_line[i][pos] = bits[k];
        pos++;
      end
    end
    last_end[i] = pos;
    pend[i].push_back(s);
  endtask

  // Reference model and per-cycle comparison.
  initial begin
    for (int i = 0; i < NI; i++) begin
      last_end[i] = 0;
      for (int t = 0; t < NCYC; t++) exp_line[i][t] = 1'b1;
    end
    cyc = 0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        if (rst[i] === 1'b1) begin
          pend[i].delete();
          last_end[i] = 0;
          for (int t = cyc; t < NCYC; t++) exp_line[i][t] = 1'b1;
        end else begin
          if (vld[i] === 1'b1 && pend[i].size() < DEPTH) schedule(i, cyc, dat[i]);
          while (pend[i].size() > 0 && pend[i][0] <= cyc) void'(pend[i].pop_front());
        end
      end
      #1;
      if (cyc < NCYC) begin
        for (int i = 0; i < NI; i++) begin
          check($sformatf("line%0d", i),  32'(tx[i]),   32'(exp_line[i][cyc]));
          check($sformatf("busy%0d", i),  32'(busy[i]), 32'((pend[i].size() > 0) || (cyc < last_end[i])));
          check($sformatf("ready%0d", i), 32'(rdy[i]),  32'(pend[i].size() < DEPTH));
          check($sformatf("count%0d", i), 32'(cnt[i]),  32'(pend[i].size()));
        end
      end
      cyc++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input int i, input logic [15:0] d);
    int n;
    n = 0;
    while (rdy[i] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(rdy[i]), 32'd1);
    vld[i] = 1'b1;
    dat[i] = d;
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  initial begin
    int acc;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1;
      vld[i] = 1'b0;
      dat[i] = '0;
    end
    idle(2);
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;

    // Plain 8N1 frame.
    push_word(0, 16'h00A5);
    idle(11 * P + 4);

    // Even and odd parity of 0x07.
    push_word(1, 16'h0007);
    push_word(2, 16'h0007);
    idle(12 * P + 4);

    // Two stop bits, back-to-back frames.
    push_word(2, 16'h0000);
    push_word(2, 16'h00FF);
    idle(2 * 12 * P + 4);

    // Held valid for six words into a depth-4 FIFO.
    acc = 0;
    for (int w = 1; w <= 6; w++) begin
      vld[0] = 1'b1;
      dat[0] = 16'(w);
      if (rdy[0] === 1'b1) acc++;
      @(negedge clk);
    end
    vld[0] = 1'b0;
    check("burst_accepted", 32'(acc), 32'd5);
    idle(5 * 10 * P + 4);

    // 12-bit word.
    push_word(3, 16'h0ABC);
    idle(16 * P + 4);

    // Reset in the middle of the data bits with two words queued.
    for (int w = 0; w < 3; w++) begin
      vld[0] = 1'b1;
      dat[0] = 16'(8'h11 * (w + 1));
      @(negedge clk);
    end
    vld[0] = 1'b0;
    idle(3 * P);
    check("pre_rst_count", 32'(cnt[0]), 32'd2);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("rst_line",  32'(tx[0]),   32'd1);
    check("rst_count", 32'(cnt[0]),  32'd0);
    check("rst_busy",  32'(busy[0]), 32'd0);
    check("rst_ready", 32'(rdy[0]),  32'd1);
    idle(20 * P);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++) begin
        rst[i] = ($urandom_range(0, 599) == 0);
        vld[i] = ($urandom_range(0, 99) < 30);
        dat[i] = 16'($urandom);
      end
      @(negedge clk);
    end
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b0;
      vld[i] = 1'b0;
    end
    idle(5 * 16 * P + 10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_transmit_framed.md
# uart_transmit_framed

Parametrised UART transmitter that succeeds the single-word transmitter. It adds configurable data width, optional even/odd parity and one or two stop bits. A valid/ready input handshake feeds an internal word FIFO, so producers such as the keychain command logic can queue several words. Frames are sent back to back on `tx_wire_out` with no idle gap while the FIFO holds data.

## Interface
- `INPUT_CLOCK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, 9600: bits per second. `BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE` (integer division), ≥ 2.
- `DATA_WIDTH`, 8: data bits per frame, 5..16.
- `PARITY`, PARITY_NONE: PARITY_NONE, PARITY_EVEN or PARITY_ODD (package enum).
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: words of buffering, power of two ≥ 2.

Ports:
- `clk_in` input 1: the single clock.
- `rst_in` input 1: reset, synchronous, active-high.
- `data_in` input DATA_WIDTH: word to send.
- `valid_in` input 1: `data_in` is valid.
- `ready_out` output 1: FIFO can accept a word. High iff not full.
- `busy_out` output 1: high iff the FSM is not IDLE or the FIFO is non-empty.
- `fifo_count_out` output $clog2(FIFO_DEPTH)+1: words currently queued.
- `tx_wire_out` output 1: serial line, idle high.

## Operation
- **Push:** a word is written on any edge where `valid_in && ready_out`. If `ready_out` is low, `valid_in` is ignored and the word is not stored.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** holds `tx_wire_out`=1. When the FIFO is non-empty, on that edge:
  - pop the head word into the shift register;
  - compute the parity bit: even = XOR of the data bits, odd = its inverse;
  - drive `tx_wire_out`=0 and enter START.
- **Bit order:**
  - START: 0.
  - DATA: DATA_WIDTH bits, LSB first.
  - PARITY: the parity bit; skipped when PARITY_NONE.
  - STOP: STOP_BITS × 1.
- **Bit duration:** each bit holds exactly BAUD_BIT_PERIOD cycles. `tx_wire_out` is registered and changes on the same edge the FSM moves to the next bit.
- **End of last stop bit:** if the FIFO is non-empty, pop and go directly to START (line goes low on that edge). Otherwise go to IDLE.
- **Frame length:** BAUD_BIT_PERIOD × (1 + DATA_WIDTH + (PARITY≠NONE) + STOP_BITS) cycles.
- **Simultaneous push and pop:** count is unchanged and both operations take effect.
- **Full FIFO:** a pop on the same edge does not raise `ready_out` until the next cycle, because `ready_out` is derived from the registered count.
- **Pointer wrap:** FIFO pointers wrap modulo FIFO_DEPTH. Count saturates structurally at FIFO_DEPTH, since pushes are blocked when full.
- **Data capture:** the word is captured at the pop. Later changes to `data_in` or FIFO contents do not affect the frame in flight.

## Timing
- **Reset values:**
  - `tx_wire_out`=1, `busy_out`=0, `ready_out`=1, `fifo_count_out`=0.
  - FSM in IDLE, bit and baud counters 0, FIFO emptied.
- **Reset mid-frame:** the frame is aborted, the line is high on the next edge and queued words are discarded.
- **Latency into an idle, empty block:**
  - word accepted at edge k;
  - start bit begins at edge k+1;
  - `busy_out` is high from edge k.
- **Back-to-back frames:** no idle cycles between the last stop bit of one frame and the start bit of the next.
- **Counters:**
  - baud counter is $clog2(BAUD_BIT_PERIOD) bits and counts 0..BAUD_BIT_PERIOD-1;
  - bit counter is $clog2(DATA_WIDTH+1) bits;
  - the STOP sub-counter counts to STOP_BITS.

## Structure
- **Package `uart_pkg`:**
  - `parity_t` enum (PARITY_NONE, PARITY_EVEN, PARITY_ODD);
  - `uart_tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - shared with the future receiver.
- **Sub-module `uart_fifo`:**
  - synchronous FIFO parametrised by WIDTH and DEPTH;
  - ports: push, pop, full, empty, count;
  - read data valid the same cycle as `empty`=0 (show-ahead).
- **Top level:** the FSM, baud counter and shift register.

## Test plan
All scenarios use INPUT_CLOCK_FREQ=16, BAUD_RATE=1 (period 16 cycles). Scenarios 1–4 and 6 use DATA_WIDTH=8, PARITY_NONE, STOP_BITS=1.
1. Push 8'hA5 into an idle block → line low for 16 cycles starting 1 cycle after acceptance, then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then high for 16; `busy_out` falls at the end of the stop bit.
2. Set PARITY_EVEN, push 8'h07 → parity bit 1; set PARITY_ODD, push 8'h07 → parity bit 0. Frame is 11×16 cycles.
3. Set STOP_BITS=2, push 8'h00 then 8'hFF back to back → the first frame's stop level lasts 32 cycles and the second start bit follows immediately, with 0 idle cycles.
4. With FIFO_DEPTH=4, hold `valid_in` for 6 cycles with data 1..6 → `ready_out` falls after 5 accepted words (1 popped plus 4 queued), word 6 is not stored, and frames 1..5 are transmitted in order.
5. DATA_WIDTH=12, push 12'hABC → 12 data bits sent LSB first: 0,0,1,1,1,1,0,1,0,1,0,1.
6. Assert `rst_in` for 1 cycle in the middle of the DATA phase with 2 words queued → line high on the next edge, `fifo_count_out`=0, `busy_out`=0, and no further frames are sent.
